// File: rtl/fetch_decode_if.sv
// Bus between the CHIP-8 fetch/decode front end, program memory and execute.
//
// Handshake: a decoded instruction is offered while out_valid=1 and is taken
// on the first rising edge where out_valid=1 and stalled=0; while stalled=1
// every decoded output stays frozen. branching is a one-cycle redirect pulse
// that overrides the handshake. mem_rdata answers mem_addr/mem_rd one cycle later.
interface fetch_decode_if;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        stalled;
    logic        branching;
    logic [11:0] branch_target;
    logic [15:0] instruction;
    logic [7:0]  opcode;
    logic [7:0]  r1;
    logic [7:0]  r2;
    logic [11:0] immediate;
    logic [11:0] pc_out;
    logic        out_valid;
    logic        decode_trap;

    modport master (
        input  mem_rdata, stalled, branching, branch_target,
        output mem_addr, mem_rd, instruction, opcode, r1, r2, immediate,
               pc_out, out_valid, decode_trap
    );

    modport slave (
        output mem_rdata, stalled, branching, branch_target,
        input  mem_addr, mem_rd, instruction, opcode, r1, r2, immediate,
               pc_out, out_valid, decode_trap
    );
endinterface

// File: rtl/fetch_decode.sv
// CHIP-8 front end: fetches big-endian 16-bit words, decodes them into the
// execute opcode enumeration and holds the result until execute accepts it.
module fetch_decode #(
    parameter logic [11:0] PC_RESET = 12'h200
) (
    input  logic              clk,
    input  logic              rst,
    fetch_decode_if.master    bus,
    output logic [1:0]        dbg_state_o
);
    typedef enum logic [1:0] {S_HI, S_LO, S_CAP, S_VALID} state_t;

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] instr_q, instr_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  r1_q, r1_d;
    logic [7:0]  r2_q, r2_d;
    logic [11:0] imm_q, imm_d;
    logic [11:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic        trap_q, trap_d;

    logic [15:0] word;
    logic [7:0]  dec_op;
    logic [11:0] dec_imm;

    // Decode the word being completed this cycle (hi byte latched, lo byte on the bus).
    always_comb begin
        word   = {hi_q, bus.mem_rdata};
        dec_op = 8'hFF;
        case (word[15:12])
            4'h0: begin
                if (word == 16'h00E0)      dec_op = 8'd1;
                else if (word == 16'h00EE) dec_op = 8'd2;
                else                       dec_op = 8'd0;
            end
            4'h1: dec_op = 8'd3;
            4'h2: dec_op = 8'd5;
            4'h3: dec_op = 8'd6;
            4'h4: dec_op = 8'd8;
            4'h5: if (word[3:0] == 4'h0) dec_op = 8'd7;
            4'h6: dec_op = 8'd10;
            4'h7: dec_op = 8'd21;
            4'h8: begin
                case (word[3:0])
                    4'h0: dec_op = 8'd11;
                    4'h1: dec_op = 8'd26;
                    4'h2: dec_op = 8'd27;
                    4'h3: dec_op = 8'd28;
                    4'h4: dec_op = 8'd22;
                    4'h5: dec_op = 8'd24;
                    4'h6: dec_op = 8'd29;
                    4'h7: dec_op = 8'd25;
                    4'hE: dec_op = 8'd30;
                    default: ;
                endcase
            end
            4'h9: if (word[3:0] == 4'h0) dec_op = 8'd9;
            4'hA: dec_op = 8'd12;
            4'hB: dec_op = 8'd4;
            4'hC: dec_op = 8'd31;
            4'hD: dec_op = 8'd32;
            4'hE: begin
                case (word[7:0])
                    8'h9E: dec_op = 8'd33;
                    8'hA1: dec_op = 8'd34;
                    default: ;
                endcase
            end
            4'hF: begin
                case (word[7:0])
                    8'h07: dec_op = 8'd13;
                    8'h0A: dec_op = 8'd14;
                    8'h15: dec_op = 8'd15;
                    8'h18: dec_op = 8'd16;
                    8'h1E: dec_op = 8'd22;
                    8'h29: dec_op = 8'd17;
                    8'h33: dec_op = 8'd18;
                    8'h55: dec_op = 8'd19;
                    8'h65: dec_op = 8'd20;
                    default: ;
                endcase
            end
            default: ;
        endcase

        case (dec_op)
            8'd0, 8'd3, 8'd4, 8'd5, 8'd12:      dec_imm = word[11:0];
            8'd6, 8'd8, 8'd10, 8'd21, 8'd31:    dec_imm = {4'h0, word[7:0]};
            8'd32:                              dec_imm = {8'h00, word[3:0]};
            default:                            dec_imm = 12'h000;
        endcase
    end

    // Next-state logic: branch overrides everything, otherwise walk the fetch sequence.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        hi_d     = hi_q;
        instr_d  = instr_q;
        opcode_d = opcode_q;
        r1_d     = r1_q;
        r2_d     = r2_q;
        imm_d    = imm_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        trap_d   = trap_q;

        if (bus.branching) begin
            pc_d    = bus.branch_target;
            valid_d = 1'b0;
            state_d = S_HI;
        end else begin
            case (state_q)
                S_HI:  state_d = S_LO;
                S_LO: begin
                    hi_d    = bus.mem_rdata;
                    state_d = S_CAP;
                end
                S_CAP: begin
                    instr_d  = word;
                    opcode_d = dec_op;
                    r1_d     = {4'h0, word[11:8]};
                    r2_d     = {4'h0, word[7:4]};
                    imm_d    = dec_imm;
                    trap_d   = (dec_op == 8'hFF);
                    pc_out_d = pc_q;
                    pc_d     = pc_q + 12'd2;
                    valid_d  = 1'b1;
                    state_d  = S_VALID;
                end
                S_VALID: begin
                    if (!bus.stalled) begin
                        valid_d = 1'b0;
                        state_d = S_HI;
                    end
                end
                default: state_d = S_HI;
            endcase
        end
    end

    // State and held-output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_HI;
            pc_q     <= PC_RESET;
            hi_q     <= 8'h00;
            instr_q  <= 16'h0000;
            opcode_q <= 8'h00;
            r1_q     <= 8'h00;
            r2_q     <= 8'h00;
            imm_q    <= 12'h000;
            pc_out_q <= 12'h000;
            valid_q  <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            hi_q     <= hi_d;
            instr_q  <= instr_d;
            opcode_q <= opcode_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            imm_q    <= imm_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            trap_q   <= trap_d;
        end
    end

    // Memory request and held outputs; the lo-byte address wraps within 4 KiB.
    always_comb begin
        bus.mem_rd      = rst && ((state_q == S_HI) || (state_q == S_LO));
        bus.mem_addr    = (state_q == S_LO) ? (pc_q + 12'd1) : pc_q;
        bus.instruction = instr_q;
        bus.opcode      = opcode_q;
        bus.r1          = r1_q;
        bus.r2          = r2_q;
        bus.immediate   = imm_q;
        bus.pc_out      = pc_out_q;
        bus.out_valid   = valid_q;
        bus.decode_trap = trap_q;
        dbg_state_o     = state_q;
    end
endmodule

// File: doc/fetch_decode.md
# fetch_decode

Front end of the CHIP-8 pipeline: fetches 16-bit big-endian instructions from program memory, decodes them into the 0–34 opcode enumeration, operand indices and immediate consumed by `execute`, and holds each decoded instruction until execute accepts it. It honours execute's `stalled` back-pressure and redirects on `branching`.

## Interface
- `PC_RESET`, 12'h200, program counter value after reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `mem_addr`  out  12  byte address to program memory; combinational from state.
- `mem_rd`  out  1  read strobe.
- `mem_rdata`  in  8  read data, valid exactly 1 cycle after the address and strobe.
- `stalled`  in  1  execute cannot accept; held output must not change.
- `branching`  in  1  redirect request; one-cycle pulse.
- `branch_target`  in  12  new PC, sampled when `branching`=1.
- `instruction`  out  16  raw instruction word.
- `opcode`  out  8  enumerated opcode 0–34, or 8'hFF when illegal.
- `r1`  out  8  x nibble (bits 11:8), zero-extended.
- `r2`  out  8  y nibble (bits 7:4), zero-extended.
- `immediate`  out  12  operand per the rules below.
- `pc_out`  out  12  address of the held instruction.
- `out_valid`  out  1  decoded instruction held on the outputs.
- `decode_trap`  out  1  held instruction is illegal; qualified by `out_valid`.

## Operation
- FSM states: S_HI, S_LO, S_CAP, S_VALID.
- S_HI: `mem_addr`=pc, `mem_rd`=1. Next state is S_LO.
- S_LO: latch hi byte from `mem_rdata`; `mem_addr`=pc+1 (wraps mod 4096), `mem_rd`=1. Next state is S_CAP.
- S_CAP: latch lo byte; register all decoded outputs; set `out_valid`=1, `pc_out`=pc, pc<=pc+2 (mod 4096). Next state is S_VALID.
- S_VALID: outputs frozen while `stalled`=1. When `stalled`=0 the instruction is consumed: `out_valid`<=0 and the next state is S_HI.
- `branching` has priority over everything, in any state:
  - pc<=`branch_target`, `out_valid`<=0, state<=S_HI.
  - Any in-flight byte is discarded.
  - Odd targets are legal.
- Opcode map (hex instruction -> enum):
  - 0000–0FFF other than 00E0/00EE -> 0
  - 00E0 -> 1, 00EE -> 2
  - 1nnn -> 3, Bnnn -> 4, 2nnn -> 5
  - 3xkk -> 6, 5xy0 -> 7, 4xkk -> 8, 9xy0 -> 9
  - 6xkk -> 10, 8xy0 -> 11, Annn -> 12
  - Fx07 -> 13, Fx0A -> 14, Fx15 -> 15, Fx18 -> 16, Fx29 -> 17, Fx33 -> 18, Fx55 -> 19, Fx65 -> 20
  - 7xkk -> 21; 8xy4 and Fx1E -> 22 (execute distinguishes the two by `instruction`[15:12])
  - 8xy5 -> 24, 8xy7 -> 25, 8xy1 -> 26, 8xy2 -> 27, 8xy3 -> 28, 8xy6 -> 29, 8xyE -> 30
  - Cxkk -> 31, Dxyn -> 32, Ex9E -> 33, ExA1 -> 34
  - 23 is reserved and never emitted.
- Any other encoding is illegal: `opcode`=8'hFF, `decode_trap`=1, `immediate`=0. Illegal instructions are still presented and handshaken normally.
- Immediate rules:
  - Opcodes 0, 3, 4, 5, 12: nnn.
  - Opcodes 6, 8, 10, 21, 31: {4'h0, kk}.
  - Opcode 32: {8'h0, n}.
  - All others: 0.
- `r1`/`r2` always carry the nibbles, regardless of opcode.

## Timing
- Reset (`rst`=0 at an edge) values:
  - pc=`PC_RESET`, state=S_HI.
  - `out_valid`=0, `decode_trap`=0, `instruction`=0, `opcode`=0, `r1`=0, `r2`=0, `immediate`=0, `pc_out`=0.
  - `mem_rd`=0 while `rst`=0.
- Reset asserted mid-fetch or during S_VALID aborts immediately; no partial instruction survives.
- First `out_valid` is 3 cycles after the first edge with `rst`=1.
- Throughput: 4 cycles per instruction when never stalled (S_HI, S_LO, S_CAP, S_VALID).
- Branch: `out_valid` is 0 in the cycle after the pulse. `mem_addr`=`branch_target` in that same cycle. The target instruction is valid 3 cycles after the pulse.
- `branching` together with `stalled`=1 in S_VALID: the branch wins and the held instruction is dropped.
- Wrap-around: pc=0xFFF fetches hi@0xFFF, lo@0x000, then next pc=0x001. pc=0xFFE gives next pc=0x000.
- Decoded outputs change only in S_CAP (or on reset); they are stable for the whole S_VALID residency.

## Test plan
- Reset release with mem[0x200]=0x12, mem[0x201]=0x34 -> `mem_addr` 0x200 then 0x201; 3 cycles later `out_valid`=1, `opcode`=3, `immediate`=0x234, `pc_out`=0x200.
- mem[0x200..]=0x8A,0xB5 with `stalled`=1 for 5 cycles -> outputs frozen at `opcode`=24, `r1`=0x0A, `r2`=0x0B; the next fetch from 0x202 starts on the cycle after `stalled` drops.
- Decode sweep over every legal pattern plus 0x5121, 0x800F, 0xE0FF, 0xF0FF -> enums match the map; the four illegal words give `opcode`=0xFF, `decode_trap`=1.
- `branching`=1 with `branch_target`=0x3FF during S_LO -> in-flight byte dropped; next `mem_addr` is 0x3FF then 0x400, and `pc_out`=0x3FF when valid.
- Branch to 0xFFF with mem[0xFFF]=0xD1, mem[0x000]=0x25 -> `opcode`=32, `immediate`=0x005; the next fetch address is 0x001.
- `rst`=0 asserted during S_CAP -> the next cycle shows all outputs at reset values and `mem_addr`=0x200 once `rst`=1.
